// File: rtl/shader_load_ctrl_if.sv
// Bus between the shader program-load controller, the SPI receiver, the
// frame timing generator and the shader instruction memory.
interface shader_load_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             spi_cs_i;
  logic             load_req_i;
  logic             frame_start_i;
  logic             rx_load_i;
  logic [7:0]       rx_instr_i;
  logic             mode_o;
  logic [7:0]       mem_instr_o;
  logic             mem_load_o;
  logic             exec_halt_o;
  logic             busy_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic             load_done_o;

  modport master (
    output spi_cs_i, load_req_i, frame_start_i, rx_load_i, rx_instr_i,
    input  mode_o, mem_instr_o, mem_load_o, exec_halt_o, busy_o,
    input  instr_cnt_o, load_done_o
  );

  modport slave (
    input  spi_cs_i, load_req_i, frame_start_i, rx_load_i, rx_instr_i,
    output mode_o, mem_instr_o, mem_load_o, exec_halt_o, busy_o,
    output instr_cnt_o, load_done_o
  );
endinterface

// File: rtl/shader_load_ctrl.sv
// Sequences a full shader program load over SPI: owns the receiver mode bit,
// halts the core while loading and releases it on a frame boundary.
module shader_load_ctrl #(
  parameter int NUM_INSTR = 8,
  parameter int CNT_W     = $clog2(NUM_INSTR + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  shader_load_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INSTR);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_IDLE,
    ST_LOAD,
    ST_WAIT_CS,
    ST_WAIT_FRAME
  } state_t;

  state_t           state;
  logic             cs_p0;
  logic             cs_p1;
  logic             req_p0;
  logic             mode_q;
  logic [7:0]       instr_q;
  logic             mem_load_q;
  logic             halt_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic             cs_idle;
  logic             req_edge;
  logic [CNT_W-1:0] cnt_inc;

  assign cs_idle  = cs_p1;
  assign req_edge = bus.load_req_i & ~req_p0;
  assign cnt_inc  = cnt_q + CNT_ONE;

  // Stage p0/p1: chip-select synchronizer; p0 also holds the request level for edge detect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_p0  <= 1'b1;
      cs_p1  <= 1'b1;
      req_p0 <= 1'b0;
    end else begin
      cs_p0  <= bus.spi_cs_i;
      cs_p1  <= cs_p0;
      req_p0 <= bus.load_req_i;
    end
  end

  // Control FSM; every output is computed alongside the next state and registered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_RUN;
      mode_q     <= 1'b0;
      instr_q    <= 8'h00;
      mem_load_q <= 1'b0;
      halt_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      mem_load_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        ST_RUN: begin
          // A request landing in the release cycle is dropped, never queued
          if (req_edge && !done_q) begin
            state  <= ST_WAIT_IDLE;
            halt_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (cs_idle) begin
            state  <= ST_LOAD;
            mode_q <= 1'b1;
            cnt_q  <= '0;
          end
        end
        ST_LOAD: begin
          // Bursts may be split by idle chip-select gaps; only the byte count ends LOAD
          if (bus.rx_load_i && (cnt_q != LAST_CNT)) begin
            mem_load_q <= 1'b1;
            instr_q    <= bus.rx_instr_i;
            cnt_q      <= cnt_inc;
            if (cnt_inc == LAST_CNT) begin
              state <= ST_WAIT_CS;
            end
          end
        end
        ST_WAIT_CS: begin
          if (cs_idle) begin
            state  <= ST_WAIT_FRAME;
            mode_q <= 1'b0;
          end
        end
        ST_WAIT_FRAME: begin
          if (bus.frame_start_i) begin
            state  <= ST_RUN;
            halt_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_RUN;
          mode_q <= 1'b0;
          halt_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode_o      = mode_q;
  assign bus.mem_instr_o = instr_q;
  assign bus.mem_load_o  = mem_load_q;
  assign bus.exec_halt_o = halt_q;
  assign bus.busy_o      = busy_q;
  assign bus.instr_cnt_o = cnt_q;
  assign bus.load_done_o = done_q;

endmodule

// File: tb/tb_shader_load_ctrl.sv
// Bench for shader_load_ctrl: directed load scenarios plus a random soak,
// compared every cycle against a phase-level reference model.
module tb_shader_load_ctrl;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  localparam int M_RUN   = 0;
  localparam int M_ARM   = 1;
  localparam int M_FILL  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_SYNC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  shader_load_ctrl_if #(.CNT_W(CW)) ifc();

  shader_load_ctrl #(.NUM_INSTR(N), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: where the load is, and what the memory port last saw
  int       m_phase;
  bit [1:0] m_cs;
  bit       m_req;
  int       e_cnt;
  bit       e_load;
  bit [7:0] e_instr;
  bit       e_done;

  task automatic m_reset();
    m_phase = M_RUN;
    m_cs    = 2'b11;
    m_req   = 1'b0;
    e_cnt   = 0;
    e_load  = 1'b0;
    e_instr = 8'h00;
    e_done  = 1'b0;
  endtask

  task automatic m_step();
    bit idle;
    bit rise;
    bit was_done;
    idle     = m_cs[1];
    rise     = ifc.load_req_i && !m_req;
    was_done = e_done;
    e_load   = 1'b0;
    e_done   = 1'b0;
    if (m_phase == M_RUN) begin
      if (rise && !was_done) m_phase = M_ARM;
    end else if (m_phase == M_ARM) begin
      if (idle) begin
        m_phase = M_FILL;
        e_cnt   = 0;
      end
    end else if (m_phase == M_FILL) begin
      if (ifc.rx_load_i) begin
        e_load  = 1'b1;
        e_instr = ifc.rx_instr_i;
        e_cnt   = e_cnt + 1;
        if (e_cnt == N) m_phase = M_DRAIN;
      end
    end else if (m_phase == M_DRAIN) begin
      if (idle) m_phase = M_SYNC;
    end else if (m_phase == M_SYNC) begin
      if (ifc.frame_start_i) begin
        m_phase = M_RUN;
        e_done  = 1'b1;
      end
    end
    m_cs  = {m_cs[0], ifc.spi_cs_i};
    m_req = ifc.load_req_i;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  task automatic chk(input string nm, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mode",      int'(ifc.mode_o),      int'(m_phase == M_FILL || m_phase == M_DRAIN));
      chk("halt",      int'(ifc.exec_halt_o), int'(m_phase != M_RUN));
      chk("busy",      int'(ifc.busy_o),      int'(m_phase != M_RUN));
      chk("cnt",       int'(ifc.instr_cnt_o), e_cnt);
      chk("mem_load",  int'(ifc.mem_load_o),  int'(e_load));
      chk("mem_instr", int'(ifc.mem_instr_o), int'(e_instr));
      chk("load_done", int'(ifc.load_done_o), int'(e_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    ifc.load_req_i = 1'b1;
    tick();
    ifc.load_req_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input string nm);
    ifc.rx_load_i  = 1'b1;
    ifc.rx_instr_i = b;
    tick();
    ifc.rx_load_i  = 1'b0;
    chk({nm, "_strobe"}, int'(ifc.mem_load_o), 1);
    chk({nm, "_byte"},   int'(ifc.mem_instr_o), int'(b));
  endtask

  task automatic pulse_frame();
    ifc.frame_start_i = 1'b1;
    tick();
    ifc.frame_start_i = 1'b0;
  endtask

  initial begin
    ifc.spi_cs_i      = 1'b1;
    ifc.load_req_i    = 1'b0;
    ifc.frame_start_i = 1'b0;
    ifc.rx_load_i     = 1'b0;
    ifc.rx_instr_i    = 8'h00;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_mode", int'(ifc.mode_o), 0);
    chk("rst_halt", int'(ifc.exec_halt_o), 0);
    chk("rst_busy", int'(ifc.busy_o), 0);
    chk("rst_cnt",  int'(ifc.instr_cnt_o), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Nominal load with chip-select idle throughout
    pulse_req();
    chk("t1_halt_after_edge", int'(ifc.exec_halt_o), 1);
    chk("t1_mode_edge_plus1", int'(ifc.mode_o), 0);
    tick();
    chk("t1_mode_edge_plus2", int'(ifc.mode_o), 1);
    for (int i = 1; i <= N; i++) send_byte(8'(8'h11 * i), "t1");
    chk("t1_cnt_full", int'(ifc.instr_cnt_o), 8);
    chk("t1_mode_wait_cs", int'(ifc.mode_o), 1);
    tick();
    chk("t1_mode_wait_frame", int'(ifc.mode_o), 0);
    repeat (3) tick();
    pulse_frame();
    chk("t1_done", int'(ifc.load_done_o), 1);
    chk("t1_halt_release", int'(ifc.exec_halt_o), 0);
    tick();
    chk("t1_done_one_cycle", int'(ifc.load_done_o), 0);

    // Request while chip-select is active, then a split burst
    ifc.spi_cs_i = 1'b0;
    repeat (50) tick();
    pulse_req();
    for (int i = 0; i < 5; i++) begin
      chk("t2_halt_cs_busy", int'(ifc.exec_halt_o), 1);
      chk("t2_mode_cs_busy", int'(ifc.mode_o), 0);
      tick();
    end
    ifc.spi_cs_i = 1'b1;
    tick();
    chk("t2_mode_sync1", int'(ifc.mode_o), 0);
    tick();
    chk("t2_mode_sync2", int'(ifc.mode_o), 0);
    tick();
    chk("t2_mode_on", int'(ifc.mode_o), 1);
    ifc.spi_cs_i = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), "t3a");
    ifc.spi_cs_i = 1'b1;
    repeat (20) tick();
    chk("t3_gap_cnt", int'(ifc.instr_cnt_o), 3);
    chk("t3_gap_mode", int'(ifc.mode_o), 1);
    ifc.spi_cs_i = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), "t3b");
    chk("t3_cnt_full", int'(ifc.instr_cnt_o), 8);
    repeat (3) tick();
    chk("t3_wait_cs_mode", int'(ifc.mode_o), 1);

    // Overflow byte in WAIT_CS
    ifc.rx_load_i = 1'b1;
    ifc.rx_instr_i = 8'hEE;
    tick();
    ifc.rx_load_i = 1'b0;
    chk("t4_overflow_strobe", int'(ifc.mem_load_o), 0);
    chk("t4_overflow_cnt", int'(ifc.instr_cnt_o), 8);
    ifc.spi_cs_i = 1'b1;
    repeat (3) tick();
    chk("t4_mode_off", int'(ifc.mode_o), 0);

    // Second request during WAIT_FRAME is ignored
    pulse_req();
    tick();
    chk("t5_busy_wait_frame", int'(ifc.busy_o), 1);
    pulse_frame();
    chk("t5_done", int'(ifc.load_done_o), 1);
    repeat (4) tick();
    chk("t5_req_not_queued", int'(ifc.busy_o), 0);

    // Stray byte in RUN
    ifc.rx_load_i = 1'b1;
    tick();
    ifc.rx_load_i = 1'b0;
    chk("t4_run_strobe", int'(ifc.mem_load_o), 0);
    chk("t4_run_cnt", int'(ifc.instr_cnt_o), 8);

    // Frame during LOAD, frame on WAIT_FRAME entry, request in release cycle
    pulse_req();
    tick();
    pulse_frame();
    chk("t5_frame_in_load", int'(ifc.mode_o), 1);
    for (int i = 0; i < N; i++) send_byte(8'($urandom), "t5");
    pulse_frame();
    chk("t5_entry_frame_busy", int'(ifc.busy_o), 1);
    chk("t5_entry_frame_done", int'(ifc.load_done_o), 0);
    repeat (2) tick();
    pulse_frame();
    chk("t5_release", int'(ifc.load_done_o), 1);
    pulse_req();
    chk("t5_req_on_done", int'(ifc.busy_o), 0);
    tick();
    chk("t5_req_on_done2", int'(ifc.busy_o), 0);

    // Reset mid-load
    pulse_req();
    tick();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), "t6");
    rst = 1'b1;
    #1;
    chk("t6_rst_mode", int'(ifc.mode_o), 0);
    chk("t6_rst_halt", int'(ifc.exec_halt_o), 0);
    chk("t6_rst_cnt",  int'(ifc.instr_cnt_o), 0);
    chk("t6_rst_instr", int'(ifc.mem_instr_o), 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_req();
    tick();
    chk("t6_restart_cnt", int'(ifc.instr_cnt_o), 0);
    send_byte(8'h5A, "t6r");
    chk("t6_restart_cnt1", int'(ifc.instr_cnt_o), 1);

    // Random soak
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) ifc.spi_cs_i = ~ifc.spi_cs_i;
      if ($urandom_range(0, 29) == 0) ifc.load_req_i = ~ifc.load_req_i;
      ifc.rx_load_i     = ($urandom_range(0, 9) < 4);
      ifc.rx_instr_i    = 8'($urandom);
      ifc.frame_start_i = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    ifc.rx_load_i = 1'b0;
    ifc.frame_start_i = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shader_load_ctrl.md
Name: shader_load_ctrl

Overview:
- Sequences loading of a complete shader program over SPI into the instruction shift-register memory.
- Owns the SPI receiver's mode input: command mode for normal operation, data mode for a program load.
- Switches mode only while chip-select is idle, counts exactly NUM_INSTR instruction bytes, and halts the shader core while loading.
- Releases the shader core only on a frame boundary, so no frame is rendered from a half-written program.

Parameters:
- NUM_INSTR, 8: number of instruction bytes in one full program.
- CNT_W, $clog2(NUM_INSTR+1): width of the instruction counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-high.
- spi_cs_i  in  1  raw SPI chip-select, active-low. Synchronized internally.
- load_req_i  in  1  program-load request level from a config register bit. Acts on its rising edge.
- frame_start_i  in  1  one-cycle pulse at the start of each frame, from the timing generator.
- rx_load_i  in  1  one-cycle pulse from the SPI receiver: one instruction byte is complete.
- rx_instr_i  in  8  instruction byte from the SPI receiver. Valid when rx_load_i=1.
- mode_o  out  1  mode select to the SPI receiver: 0 = command mode, 1 = data mode.
- mem_instr_o  out  8  instruction byte to the shader memory.
- mem_load_o  out  1  one-cycle shift/load strobe to the shader memory.
- exec_halt_o  out  1  holds the shader core.
- busy_o  out  1  high in every state except RUN.
- instr_cnt_o  out  CNT_W  number of bytes accepted in the current load.
- load_done_o  out  1  one-cycle pulse when the shader core resumes with the new program.

Behaviour:
- Reset values:
  - State RUN.
  - mode_o=0, mem_instr_o=0, mem_load_o=0, exec_halt_o=0, busy_o=0, instr_cnt_o=0, load_done_o=0.
  - The 2-FF cs synchronizer resets to 1 (idle).
  - The load_req_i edge-detect register resets to 0.
- Reset asserted mid-operation aborts any load and returns to the reset values. Bytes already written to the shader memory stay there.
- Signal conditioning:
  - cs_idle = synchronized spi_cs_i equals 1.
  - req_edge = load_req_i is 1 and its registered copy is 0.
- All outputs are registered.
- State machine:
  - RUN: mode_o=0, exec_halt_o=0.
    - req_edge -> WAIT_IDLE.
  - WAIT_IDLE: exec_halt_o=1. mode_o stays 0.
    - cs_idle -> LOAD; clear instr_cnt to 0.
    - Otherwise wait, with no timeout.
  - LOAD: mode_o=1, exec_halt_o=1.
    - On each rx_load_i: the next cycle drives mem_load_o=1 and mem_instr_o=rx_instr_i, and instr_cnt increments. Latency is exactly 1 cycle.
    - When instr_cnt reaches NUM_INSTR -> WAIT_CS.
    - A cs_idle gap during LOAD (a partial burst) does not leave LOAD. The count persists across bursts.
  - WAIT_CS: mode_o=1, exec_halt_o=1.
    - cs_idle -> WAIT_FRAME.
  - WAIT_FRAME: mode_o=0, exec_halt_o=1.
    - frame_start_i -> RUN, with load_done_o=1 for that one cycle.
- rx_load_i outside LOAD, or past NUM_INSTR bytes, is dropped: no mem_load_o and no count change.
- mem_instr_o holds its last value when mem_load_o=0.
- req_edge outside RUN is ignored and not queued. A req_edge in the same cycle that load_done_o pulses is also ignored.
- Simultaneous events:
  - rx_load_i for the final byte and cs going idle in the same cycle: the byte is accepted and the state goes to WAIT_CS. WAIT_CS sees cs_idle on the next cycle and moves to WAIT_FRAME.
  - frame_start_i only counts while the state is already WAIT_FRAME. A pulse in the same cycle the state enters WAIT_FRAME is not counted.
- mode_o only ever changes while cs_idle=1. The controller never switches mode in the middle of a byte.

Test Plan:
1. Nominal load, NUM_INSTR=8, cs idle:
   - Stimulus: pulse load_req_i, send 8 rx_load_i bytes 0x11..0x88, raise cs, then pulse frame_start_i.
   - Required: mode_o goes 1 two cycles after the request edge. 8 mem_load_o pulses, each 1 cycle after its rx_load_i, carrying 0x11..0x88. mode_o returns to 0 after cs goes idle. load_done_o pulses on the frame_start_i cycle +1. exec_halt_o falls on that same cycle.
2. Request while cs is active:
   - Stimulus: hold cs low for 50 cycles, then pulse load_req_i.
   - Required: exec_halt_o=1 and mode_o=0 until cs is synchronized idle, then mode_o=1.
3. Split burst:
   - Stimulus: 3 bytes, cs idle for 20 cycles, then 5 bytes.
   - Required: instr_cnt_o reads 3 during the gap and state stays LOAD. After byte 8 the state is WAIT_CS.
4. Overflow and stray bytes:
   - Stimulus: a 9th rx_load_i in WAIT_CS, plus rx_load_i while in RUN.
   - Required: no mem_load_o pulse and instr_cnt_o stays at 8.
5. Frame alignment and request ignore:
   - Stimulus: frame_start_i during LOAD, and a second load_req_i edge during WAIT_FRAME.
   - Required: both ignored. Release only on the first frame_start_i seen in WAIT_FRAME.
6. Reset mid-load:
   - Stimulus: assert rst_i after 4 bytes.
   - Required: all outputs return to reset values immediately. After reset release, a fresh request restarts counting from 0.
